// File: rtl/trafficgen_axil_stream.sv
// AXI4-Lite register bank controlling an AXI4-Stream pattern source
// (incrementing or Galois-LFSR beats, one-shot or continuous runs).
module trafficgen_axil_stream #(
  parameter int NUM_USER_REGS      = 4,
  parameter int C_S_AXI_ADDR_WIDTH = 7,
  parameter int TDATA_WIDTH        = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [31:0]                   s_axi_wdata,
  input  logic [3:0]                    s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [31:0]                   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [TDATA_WIDTH-1:0]        m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast
);

  localparam int IDX_W     = C_S_AXI_ADDR_WIDTH - 2;
  localparam int NUM_WORDS = 5 + NUM_USER_REGS;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_next;
  logic        aw_rdy, ar_rdy, bvalid, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, rd_val;
  logic        ctrl_mode, ctrl_cont;
  logic [31:0] seed, beat_count, sent, cur, run_count;
  logic        run_mode, run_cont, stop_pending, done;
  logic [31:0] user_regs [NUM_USER_REGS];

  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic wr_fire, rd_fire, wr_mapped, rd_mapped;
  logic ctrl_wr, start_req, stop_req, clr_done, eff_mode, eff_cont;
  logic empty_start, hs, last_beat, run_end, tvalid, tlast;

  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] din,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = din[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

  assign wr_idx    = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx    = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_fire   = aw_rdy && s_axi_awvalid && s_axi_wvalid;
  assign rd_fire   = ar_rdy && s_axi_arvalid;
  assign wr_mapped = int'(wr_idx) < NUM_WORDS;
  assign rd_mapped = int'(rd_idx) < NUM_WORDS;

  // START/STOP act on the value being written so mode/cont written with START take effect at once
  assign ctrl_wr     = wr_fire && (int'(wr_idx) == 0) && s_axi_wstrb[0];
  assign start_req   = ctrl_wr && s_axi_wdata[0];
  assign stop_req    = ctrl_wr && s_axi_wdata[3];
  assign eff_mode    = ctrl_wr ? s_axi_wdata[1] : ctrl_mode;
  assign eff_cont    = ctrl_wr ? s_axi_wdata[2] : ctrl_cont;
  assign clr_done    = wr_fire && (int'(wr_idx) == 3) && s_axi_wstrb[0] && s_axi_wdata[1];
  assign empty_start = start_req && (beat_count == 32'd0) && !eff_cont;

  assign hs        = (state == RUN) && m_axis_tready;
  assign last_beat = !run_cont && (sent + 32'd1 == run_count);
  assign run_end   = hs && (last_beat || stop_pending || stop_req);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_rdy <= 1'b0;
      bvalid <= 1'b0;
      bresp  <= 2'b00;
    end else begin
      aw_rdy <= !aw_rdy && s_axi_awvalid && s_axi_wvalid && !bvalid;
      if (wr_fire) begin
        bvalid <= 1'b1;
        bresp  <= wr_mapped ? 2'b00 : 2'b10;
      end else if (s_axi_bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ctrl_mode  <= 1'b0;
      ctrl_cont  <= 1'b0;
      seed       <= '0;
      beat_count <= '0;
      for (int k = 0; k < NUM_USER_REGS; k++) user_regs[k] <= '0;
    end else if (wr_fire) begin
      if (ctrl_wr) begin
        ctrl_mode <= s_axi_wdata[1];
        ctrl_cont <= s_axi_wdata[2];
      end
      if (int'(wr_idx) == 1) seed       <= apply_strb(seed, s_axi_wdata, s_axi_wstrb);
      if (int'(wr_idx) == 2) beat_count <= apply_strb(beat_count, s_axi_wdata, s_axi_wstrb);
      for (int k = 0; k < NUM_USER_REGS; k++)
        if (int'(wr_idx) == 5 + k) user_regs[k] <= apply_strb(user_regs[k], s_axi_wdata, s_axi_wstrb);
    end
  end

  always_comb begin
    rd_val = '0;
    case (int'(rd_idx))
      0: rd_val = {28'd0, 1'b0, ctrl_cont, ctrl_mode, 1'b0};
      1: rd_val = seed;
      2: rd_val = beat_count;
      3: rd_val = {30'd0, done, state == RUN};
      4: rd_val = sent;
      default: begin
        for (int k = 0; k < NUM_USER_REGS; k++)
          if (int'(rd_idx) == 5 + k) rd_val = user_regs[k];
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ar_rdy <= 1'b0;
      rvalid <= 1'b0;
      rresp  <= 2'b00;
      rdata  <= '0;
    end else begin
      ar_rdy <= !ar_rdy && s_axi_arvalid && !rvalid;
      if (rd_fire) begin
        rvalid <= 1'b1;
        rdata  <= rd_val;
        rresp  <= rd_mapped ? 2'b00 : 2'b10;
      end else if (s_axi_rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_req && !empty_start) state_next = RUN;
      RUN:  if (run_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tvalid = 1'b0;
    tlast  = 1'b0;
    if (state == RUN) begin
      tvalid = 1'b1;
      tlast  = last_beat;
    end
  end

  // Run parameters are latched at START so register writes mid-run cannot disturb tlast
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cur          <= '0;
      sent         <= '0;
      run_mode     <= 1'b0;
      run_cont     <= 1'b0;
      run_count    <= '0;
      stop_pending <= 1'b0;
      done         <= 1'b0;
    end else begin
      if (state == IDLE && start_req && !empty_start) begin
        cur          <= (eff_mode && seed == 32'd0) ? 32'd1 : seed;
        sent         <= '0;
        run_mode     <= eff_mode;
        run_cont     <= eff_cont;
        run_count    <= beat_count;
        stop_pending <= 1'b0;
      end else if (hs) begin
        cur  <= run_mode ? lfsr_next(cur) : cur + 32'd1;
        sent <= sent + 32'd1;
      end
      if (state == RUN && stop_req) stop_pending <= 1'b1;
      if (run_end)                  stop_pending <= 1'b0;
      if ((state == IDLE && empty_start) || run_end) done <= 1'b1;
      else if (clr_done)                             done <= 1'b0;
    end
  end

  if (TDATA_WIDTH == 64) begin : g_w64
    assign m_axis_tdata = {cur, cur};
  end else begin : g_w32
    assign m_axis_tdata = cur;
  end

  assign s_axi_awready = aw_rdy;
  assign s_axi_wready  = aw_rdy;
  assign s_axi_bvalid  = bvalid;
  assign s_axi_bresp   = bresp;
  assign s_axi_arready = ar_rdy;
  assign s_axi_rvalid  = rvalid;
  assign s_axi_rresp   = rresp;
  assign s_axi_rdata   = rdata;
  assign m_axis_tvalid = tvalid;
  assign m_axis_tlast  = tlast;

endmodule

// File: tb/tb_trafficgen_axil_stream.sv
// Scoreboard bench for trafficgen_axil_stream: directed AXI-Lite accesses and
// stream runs push expected responses; monitors pop and compare on handshakes.
module tb_trafficgen_axil_stream;
  localparam int AW = 7;
  localparam int TW = 32;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [AW-1:0] s_axi_awaddr = '0;
  logic          s_axi_awvalid = 1'b0, s_axi_awready;
  logic [31:0]   s_axi_wdata = '0;
  logic [3:0]    s_axi_wstrb = 4'hF;
  logic          s_axi_wvalid = 1'b0, s_axi_wready;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid, s_axi_bready = 1'b1;
  logic [AW-1:0] s_axi_araddr = '0;
  logic          s_axi_arvalid = 1'b0, s_axi_arready;
  logic [31:0]   s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rvalid, s_axi_rready = 1'b1;
  logic [TW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast;

  trafficgen_axil_stream #(.NUM_USER_REGS(4), .C_S_AXI_ADDR_WIDTH(AW), .TDATA_WIDTH(TW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  always #5 ACLK = ~ACLK;

  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
  typedef struct { logic [31:0] data; logic last; } aexp_t;

  logic [1:0] b_q[$];
  rexp_t      r_q[$];
  aexp_t      a_q[$];
  rexp_t      r_e;
  aexp_t      a_e;

  int   n_checks = 0;
  int   n_fail = 0;
  int   tr_mode = 0;
  int   tr_budget = 0;
  int   burst_cnt = 0;
  bit   axis_ignore = 1'b0;
  logic stall_prev = 1'b0;
  logic stall_last = 1'b0;
  logic [31:0] stall_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // tready pattern: 0 low, 1 high, 2 toggle, 3 high for tr_budget cycles then low
  always @(posedge ACLK) begin
    #2;
    if (tr_mode != 3) burst_cnt = 0;
    case (tr_mode)
      0: m_axis_tready = 1'b0;
      1: m_axis_tready = 1'b1;
      2: m_axis_tready = ~m_axis_tready;
      default: begin
        if (burst_cnt < tr_budget) begin
          m_axis_tready = 1'b1;
          burst_cnt++;
        end else begin
          m_axis_tready = 1'b0;
        end
      end
    endcase
  end

  always @(negedge ACLK) begin
    if (ARESET) begin
      stall_prev = 1'b0;
    end else begin
      if (s_axi_bvalid && s_axi_bready) begin
        if (b_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b_unexpected: actual bresp %0d required no response", s_axi_bresp);
        end else chk("bresp", 32'(s_axi_bresp), 32'(b_q.pop_front()));
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (r_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL r_unexpected: actual rdata 0x%08h required no response", s_axi_rdata);
        end else begin
          r_e = r_q.pop_front();
          chk("rdata", s_axi_rdata, r_e.data);
          chk("rresp", 32'(s_axi_rresp), 32'(r_e.resp));
        end
      end
      if (axis_ignore) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("tvalid_hold", 32'(m_axis_tvalid), 32'd1);
          chk("tdata_stable", m_axis_tdata, stall_data);
          chk("tlast_stable", 32'(m_axis_tlast), 32'(stall_last));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (a_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL beat_unexpected: actual tdata 0x%08h required no beat", m_axis_tdata);
          end else begin
            a_e = a_q.pop_front();
            chk("tdata", m_axis_tdata, a_e.data);
            chk("tlast", 32'(m_axis_tlast), 32'(a_e.last));
          end
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        stall_data = m_axis_tdata;
        stall_last = m_axis_tlast;
      end
    end
  end

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp);
    bit got;
    got = 1'b0;
    @(negedge ACLK);
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    b_q.push_back(resp);
    for (int i = 0; i < 16; i++) begin
      @(negedge ACLK);
      if (s_axi_awready && s_axi_wready) begin got = 1'b1; break; end
    end
    if (got) begin
      @(posedge ACLK); #1;
    end else begin
      n_checks++; n_fail++;
      $display("FAIL aw_timeout: actual no awready required awready at 0x%02h", addr);
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    repeat (2) @(negedge ACLK);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input logic [31:0] data, input logic [1:0] resp);
    bit got;
    rexp_t e;
    got = 1'b0;
    @(negedge ACLK);
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    e.data = data; e.resp = resp;
    r_q.push_back(e);
    for (int i = 0; i < 16; i++) begin
      @(negedge ACLK);
      if (s_axi_arready) begin got = 1'b1; break; end
    end
    if (got) begin
      @(posedge ACLK); #1;
    end else begin
      n_checks++; n_fail++;
      $display("FAIL ar_timeout: actual no arready required arready at 0x%02h", addr);
    end
    s_axi_arvalid = 1'b0;
    repeat (2) @(negedge ACLK);
  endtask

  task automatic push_beat(input logic [31:0] data, input logic last);
    aexp_t e;
    e.data = data; e.last = last;
    a_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual still running required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge ACLK);
    chk("rst_awready", 32'(s_axi_awready), 32'd0);
    chk("rst_wready", 32'(s_axi_wready), 32'd0);
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rst_arready", 32'(s_axi_arready), 32'd0);
    chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    ARESET = 1'b0;

    // user bank, strobes, unmapped address
    for (int k = 0; k < 4; k++) axi_write(AW'(8'h14 + 4*k), 32'(k + 1), 4'hF, 2'b00);
    for (int k = 0; k < 4; k++) axi_read(AW'(8'h14 + 4*k), 32'(k + 1), 2'b00);
    axi_write(7'h14, 32'hAABB_CCDD, 4'b0101, 2'b00);
    axi_read(7'h14, 32'h00BB_00DD, 2'b00);
    axi_write(7'h3C, 32'hDEAD_BEEF, 4'hF, 2'b10);
    axi_read(7'h3C, 32'h0, 2'b10);

    // incrementing one-shot
    tr_mode = 1;
    push_beat(32'h100, 1'b0); push_beat(32'h101, 1'b0); push_beat(32'h102, 1'b1);
    axi_write(7'h04, 32'h100, 4'hF, 2'b00);
    axi_write(7'h08, 32'd3, 4'hF, 2'b00);
    axi_write(7'h00, 32'h1, 4'hF, 2'b00);
    repeat (5) @(negedge ACLK);
    axi_read(7'h10, 32'd3, 2'b00);
    axi_read(7'h0C, 32'h2, 2'b00);
    axi_read(7'h00, 32'h0, 2'b00);
    axi_write(7'h0C, 32'h2, 4'hF, 2'b00);
    axi_read(7'h0C, 32'h0, 2'b00);

    // LFSR with toggling backpressure, seed 0 replaced by 1
    tr_mode = 2;
    push_beat(32'h0000_0001, 1'b0); push_beat(32'h8020_0003, 1'b1);
    axi_write(7'h04, 32'h0, 4'hF, 2'b00);
    axi_write(7'h08, 32'd2, 4'hF, 2'b00);
    axi_write(7'h00, 32'h3, 4'hF, 2'b00);
    repeat (10) @(negedge ACLK);
    axi_read(7'h10, 32'd2, 2'b00);
    axi_read(7'h0C, 32'h2, 2'b00);
    axi_read(7'h00, 32'h2, 2'b00);
    axi_write(7'h0C, 32'h2, 4'hF, 2'b00);

    // continuous run: 10 beats, STOP while stalled, one more beat then done
    tr_mode = 0;
    for (int k = 0; k < 11; k++) push_beat(32'h10 + 32'(k), 1'b0);
    axi_write(7'h04, 32'h10, 4'hF, 2'b00);
    axi_write(7'h00, 32'h5, 4'hF, 2'b00);
    tr_budget = 10;
    tr_mode = 3;
    repeat (16) @(negedge ACLK);
    axi_read(7'h10, 32'd10, 2'b00);
    axi_write(7'h00, 32'hC, 4'hF, 2'b00);
    tr_mode = 1;
    repeat (6) @(negedge ACLK);
    axi_read(7'h10, 32'd11, 2'b00);
    axi_read(7'h0C, 32'h2, 2'b00);
    axi_write(7'h0C, 32'h2, 4'hF, 2'b00);

    // BEAT_COUNT=0 one-shot: DONE without beats, SENT untouched
    axi_write(7'h08, 32'd0, 4'hF, 2'b00);
    axi_write(7'h00, 32'h1, 4'hF, 2'b00);
    repeat (4) @(negedge ACLK);
    axi_read(7'h0C, 32'h2, 2'b00);
    axi_read(7'h10, 32'd11, 2'b00);
    axi_write(7'h0C, 32'h2, 4'hF, 2'b00);

    // START while busy is ignored
    tr_mode = 0;
    for (int k = 0; k < 5; k++) push_beat(32'h200 + 32'(k), k == 4);
    axi_write(7'h04, 32'h200, 4'hF, 2'b00);
    axi_write(7'h08, 32'd5, 4'hF, 2'b00);
    axi_write(7'h00, 32'h1, 4'hF, 2'b00);
    tr_budget = 2;
    tr_mode = 3;
    repeat (6) @(negedge ACLK);
    axi_write(7'h00, 32'h1, 4'hF, 2'b00);
    axi_read(7'h10, 32'd2, 2'b00);
    axi_read(7'h0C, 32'h1, 2'b00);
    tr_mode = 1;
    repeat (8) @(negedge ACLK);
    axi_read(7'h10, 32'd5, 2'b00);
    axi_read(7'h0C, 32'h2, 2'b00);

    // reset in the middle of a continuous run
    axis_ignore = 1'b1;
    axi_write(7'h04, 32'h300, 4'hF, 2'b00);
    axi_write(7'h00, 32'h5, 4'hF, 2'b00);
    repeat (4) @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("midrst_tdata", m_axis_tdata, 32'd0);
    chk("midrst_tlast", 32'(m_axis_tlast), 32'd0);
    ARESET = 1'b0;
    axis_ignore = 1'b0;
    axi_read(7'h00, 32'h0, 2'b00);
    axi_read(7'h04, 32'h0, 2'b00);
    axi_read(7'h08, 32'h0, 2'b00);
    axi_read(7'h0C, 32'h0, 2'b00);
    axi_read(7'h10, 32'h0, 2'b00);
    axi_read(7'h14, 32'h0, 2'b00);
    repeat (4) @(negedge ACLK);

    chk("b_q_empty", 32'(b_q.size()), 32'd0);
    chk("r_q_empty", 32'(r_q.size()), 32'd0);
    chk("a_q_empty", 32'(a_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
